// File: rtl/booth_final_adder.sv
// booth_final_adder: converts the redundant sum/carry pair from the 4:2
// compression tree into a binary product. The addition is done one SEG_W-bit
// segment per cycle, least significant first, with a ripple carry between
// segments.
// Optional feature: define BOOTH_FINAL_ADDER_COUT_EN to add the cout output
// (carry out of the top segment).
module booth_final_adder #(
   parameter int length = 128,
   parameter int SEG_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*length:0]     in_sum,
   input  logic [2*length:0]     in_carry,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*length-1:0]   product,
`ifdef BOOTH_FINAL_ADDER_COUT_EN
   output logic                  cout,
`endif
   output logic                  busy
);

   localparam int PW   = 2*length;
   localparam int NSEG = PW/SEG_W;
   localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t              state, state_nx;
   logic [PW-1:0]       a_q, b_q;
   logic [CW-1:0]       seg_cnt;
   logic                cy;
   // fin marks that the last segment has been written; ADD then spends one
   // more cycle before DONE so out_valid lands NSEG+1 cycles after accept
   // without letting the counter run past NSEG-1.
   logic                fin;
   logic                accept;
   logic                last_seg;
   logic [SEG_W-1:0]    a_seg, b_seg;
   logic [SEG_W:0]      seg_sum;

   // Top sum bit and the carry bits shifted past the product are dropped.
   logic unused_bits;
   assign unused_bits = ^{in_sum[PW], in_carry[PW:PW-1]};

   assign accept    = in_valid & in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state == ADD) | (state == DONE);
   assign last_seg  = (seg_cnt == CW'(NSEG-1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and input handshake; DONE hands over straight to ADD when a
   // new pair is waiting as the current product is consumed.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ADD;
         end
         ADD: begin
            if (fin) state_nx = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_nx = in_valid ? ADD : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Segment adder for the current segment index
   always_comb begin
      a_seg   = a_q[int'(seg_cnt)*SEG_W +: SEG_W];
      b_seg   = b_q[int'(seg_cnt)*SEG_W +: SEG_W];
      seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cy};
   end

   // Operand capture on accept, then one segment per cycle into product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         product <= '0;
         cy      <= 1'b0;
         seg_cnt <= '0;
         fin     <= 1'b0;
      end else if (accept) begin
         a_q     <= in_sum[PW-1:0];
         b_q     <= {in_carry[PW-2:0], 1'b0};
         cy      <= 1'b0;
         seg_cnt <= '0;
         fin     <= 1'b0;
      end else if (state == ADD && !fin) begin
         product[int'(seg_cnt)*SEG_W +: SEG_W] <= seg_sum[SEG_W-1:0];
         cy <= seg_sum[SEG_W];
         if (last_seg) fin     <= 1'b1;
         else          seg_cnt <= seg_cnt + 1'b1;
      end
   end

`ifdef BOOTH_FINAL_ADDER_COUT_EN
   // Carry out of the top segment, captured with the last segment result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                cout <= 1'b0;
      else if (accept)                           cout <= 1'b0;
      else if (state == ADD && !fin && last_seg) cout <= seg_sum[SEG_W];
   end
`endif

endmodule

// File: tb/tb_booth_final_adder.sv
// Testbench for booth_final_adder (length=128, SEG_W=32): directed vector
// table, randomized operations against an arithmetic model, and hand-written
// backpressure, back-to-back and mid-operation reset sequences.
module tb_booth_final_adder;

   localparam int L  = 128;
   localparam int PW = 2*L;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW:0]   in_sum = '0;
   logic [PW:0]   in_carry = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] product;
   logic          busy;
`ifdef BOOTH_FINAL_ADDER_COUT_EN
   logic          cout;
`endif

   int passed = 0;
   int total  = 0;

   booth_final_adder #(.length(L), .SEG_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
      .out_ready(out_ready), .product(product),
`ifdef BOOTH_FINAL_ADDER_COUT_EN
      .cout(cout),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW:0]   s;
      logic [PW:0]   c;
      logic [PW-1:0] e;
      logic          ce;
   } vec_t;

   vec_t vt[4];

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      else passed++;
   endtask

   function automatic logic [PW:0] rnd();
      logic [287:0] t;
      for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
      return t[PW:0];
   endfunction

   // Reference: (sum + 2*carry) mod 2^PW; bit PW of the result is the carry
   // out of adding the two truncated operands.
   function automatic logic [PW:0] model(input logic [PW:0] s, input logic [PW:0] c);
      logic [PW+2:0] full;
      logic [PW+2:0] ts, tc;
      ts = {3'b0, s} % (259'(1) << PW);
      tc = ({2'b0, c, 1'b0}) % (259'(1) << PW);
      full = ts + tc;
      return full[PW:0];
   endfunction

   // Wait for out_valid with a cycle bound; returns cycles since accept edge.
   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!out_valid && cnt < 30) begin
         @(negedge clk);
         cnt++;
         in_sum = rnd();
         in_carry = rnd();
      end
   endtask

   task automatic do_op(input logic [PW:0] s, input logic [PW:0] c,
                        input logic [PW-1:0] e, input logic ce, input string nm);
      int cnt;
      @(negedge clk);
      in_sum = s; in_carry = c; in_valid = 1'b1; out_ready = 1'b1;
      chk({nm, " in_ready idle"}, PW'(in_ready), PW'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_sum = rnd(); in_carry = rnd();
      wait_valid(cnt);
      chk({nm, " latency"}, PW'(cnt), PW'(9));
      chk({nm, " product"}, product, e);
`ifdef BOOTH_FINAL_ADDER_COUT_EN
      chk({nm, " cout"}, PW'(cout), PW'(ce));
`else
      if (ce === 1'bx) $display("unused cout expectation");
`endif
      @(negedge clk);
      chk({nm, " released"}, PW'(out_valid), PW'(0));
   endtask

   initial begin
      logic [PW:0]   m, s, c, s2, c2;
      logic [PW-1:0] hold;
      int cnt, hits;

      vt[0] = '{s: 257'd1, c: 257'd1, e: 256'd3, ce: 1'b0};
      vt[1] = '{s: 257'hFFFF_FFFF, c: 257'd1, e: 256'h1_0000_0001, ce: 1'b0};
      vt[2] = '{s: {1'b0, {PW{1'b1}}}, c: 257'd1, e: 256'd1, ce: 1'b1};
      vt[3] = '{s: '0, c: {(PW+1){1'b1}}, e: {{(PW-1){1'b1}}, 1'b0}, ce: 1'b0};

      // Reset state
      #2;
      chk("rst product", product, '0);
      chk("rst out_valid", PW'(out_valid), PW'(0));
      chk("rst busy", PW'(busy), PW'(0));
      chk("rst in_ready", PW'(in_ready), PW'(1));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 4; i++)
         do_op(vt[i].s, vt[i].c, vt[i].e, vt[i].ce, $sformatf("vec%0d", i));

      // Randomized against the model, with occasional all-ones operands
      for (int i = 0; i < 20; i++) begin
         s = rnd(); c = rnd();
         if (i % 5 == 1) s = {(PW+1){1'b1}};
         if (i % 7 == 2) c = {(PW+1){1'b1}};
         m = model(s, c);
         do_op(s, c, m[PW-1:0], m[PW], $sformatf("rand%0d", i));
      end

      // Backpressure: hold DONE for 5 cycles
      s = rnd(); c = rnd(); m = model(s, c);
      @(negedge clk);
      in_sum = s; in_carry = c; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      wait_valid(cnt);
      chk("bp latency", PW'(cnt), PW'(9));
      chk("bp product", product, m[PW-1:0]);
      hold = product;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_sum = rnd(); in_valid = k[0];
         chk($sformatf("bp hold valid%0d", k), PW'(out_valid), PW'(1));
         chk($sformatf("bp hold ready%0d", k), PW'(in_ready), PW'(0));
         chk($sformatf("bp hold prod%0d", k), product, hold);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1 chk("bp release in_ready", PW'(in_ready), PW'(1));
      @(negedge clk);
      chk("bp idle out_valid", PW'(out_valid), PW'(0));
      chk("bp idle busy", PW'(busy), PW'(0));

      // Back-to-back: second pair accepted in the DONE cycle
      s = rnd(); c = rnd(); s2 = rnd(); c2 = rnd();
      @(negedge clk);
      in_sum = s; in_carry = c; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(cnt);
      m = model(s, c);
      chk("b2b first latency", PW'(cnt), PW'(9));
      chk("b2b first product", product, m[PW-1:0]);
      in_sum = s2; in_carry = c2; in_valid = 1'b1;
      chk("b2b in_ready done", PW'(in_ready), PW'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b busy", PW'(busy), PW'(1));
      chk("b2b gap", PW'(out_valid), PW'(0));
      wait_valid(cnt);
      m = model(s2, c2);
      chk("b2b second latency", PW'(cnt), PW'(9));
      chk("b2b second product", product, m[PW-1:0]);
      @(negedge clk);

      // Reset during ADD at segment 3
      @(negedge clk);
      in_sum = rnd(); in_carry = rnd(); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) @(negedge clk);
      chk("mid busy before rst", PW'(busy), PW'(1));
      rst_n = 1'b0;
      #1;
      chk("mid rst product", product, '0);
      chk("mid rst out_valid", PW'(out_valid), PW'(0));
      chk("mid rst busy", PW'(busy), PW'(0));
      chk("mid rst in_ready", PW'(in_ready), PW'(1));
`ifdef BOOTH_FINAL_ADDER_COUT_EN
      chk("mid rst cout", PW'(cout), PW'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid || busy) hits++;
      end
      chk("mid rst no pulse", PW'(hits), PW'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/booth_final_adder.md
BOOTH_FINAL_ADDER -- requirements
Module: booth_final_adder

Interface
REQ-001 The block SHALL have parameter length, default 128, the multiplier operand width; the product width is 2*length bits.
REQ-002 The block SHALL have parameter SEG_W, default 32, the adder segment width; 2*length SHALL be an integer multiple of SEG_W, and NSEG = 2*length/SEG_W.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_sum/in_carry hold a valid redundant-form pair.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 in_sum  input  2*length+1  sum vector from the 4:2 compression stage.
REQ-008 in_carry  input  2*length+1  carry vector from the 4:2 compression stage; bit i carries weight 2^(i+1).
REQ-009 out_valid  output  1  product is valid.
REQ-010 out_ready  input  1  consumer accepts the product this cycle.
REQ-011 product  output  2*length  final binary product.
REQ-012 busy  output  1  high in states ADD and DONE.

Function
REQ-013 product SHALL equal (in_sum + (in_carry << 1)) mod 2^(2*length); bit 2*length of in_sum and bits above 2*length-1 of the shifted carry SHALL be discarded.
REQ-014 FSM states SHALL be IDLE, ADD and DONE.
REQ-015 in_ready SHALL be high in IDLE, and high in DONE when out_ready is high; it SHALL be low in ADD.
REQ-016 On an accept (in_valid & in_ready), the block SHALL register in_sum[2*length-1:0] and {in_carry[2*length-2:0],1'b0}, clear the segment counter and the carry flop, and enter ADD.
REQ-017 In ADD, one SEG_W-bit segment per cycle SHALL be added, least significant segment first, with the carry-in taken from the carry flop, the segment result written into product, and the carry-out stored in the carry flop.
REQ-018 After segment NSEG-1, the FSM SHALL enter DONE; out_valid SHALL rise exactly NSEG+1 cycles after the accept edge.
REQ-019 In DONE, out_valid SHALL be high and product SHALL be held stable until out_ready is high.
REQ-020 On DONE & out_ready & in_valid, the block SHALL accept the new pair in the same cycle and go directly to ADD (back-to-back operation, no idle bubble).
REQ-021 On DONE & out_ready & !in_valid, the FSM SHALL return to IDLE.
REQ-022 Input values SHALL be ignored whenever no accept occurs; a change on in_sum/in_carry during ADD SHALL NOT affect the result.
REQ-023 The segment counter SHALL be ceil(log2(NSEG)) bits wide (minimum 1) and SHALL NOT wrap inside one operation.

Reset
REQ-024 While rst_n is low, the FSM SHALL be IDLE, product SHALL be 0, the carry flop and segment counter SHALL be 0, out_valid SHALL be 0 and busy SHALL be 0.
REQ-025 While rst_n is low, in_ready SHALL follow the IDLE state and therefore be high.
REQ-026 Reset asserted mid-operation (ADD or DONE) SHALL abort the operation immediately, with no output pulse after release.

Configuration
REQ-027 With BOOTH_FINAL_ADDER_COUT_EN defined, the block SHALL have the extra output cout (1 bit): the carry-out of the top segment, registered with the last segment, valid with out_valid, and 0 at reset.
REQ-028 Without BOOTH_FINAL_ADDER_COUT_EN defined, the cout port and its flop SHALL be absent, and all other behaviour SHALL be identical.

Verification (length=128, SEG_W=32)
REQ-029 Basic sum: in_sum=1, in_carry=1, out_ready=1 -> product=3, out_valid high exactly 9 cycles after accept.
REQ-030 Carry across segments: in_sum=0xFFFFFFFF, in_carry=0 except bit0=1 -> product=0x1_00000001.
REQ-031 Wrap-around (COUT_EN defined): in_sum = all 256 bits ones, in_carry=0 except bit0=1 -> product=1, cout=1.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0; release -> in_ready=1 in the same cycle as out_ready.
REQ-033 Back-to-back: second pair presented with out_ready=1 in DONE -> accepted that cycle, second out_valid 9 cycles later, results ordered.
REQ-034 Reset mid-ADD: rst_n pulsed low at segment 3 -> all outputs return to reset values, no out_valid after release.
